conv_engine: RTL and testbench

//  3x3 2-D convolution accelerator (valid padding, stride 1) between two BRAM-style memories.

---
 rtl/conv_engine.sv | 187 ++++++++++++++++++
 tb/tb_conv_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine.sv
// conv_engine: 3x3 2-D convolution (valid padding, stride 1).
// Loads a 3x3 kernel plus bias from memory port M0, then for each output
// pixel reads the 3x3 image window from M0, accumulates bias + sum(k*in)
// with 32-bit wrap-around arithmetic, and writes the result to port M1.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 one-cycle launch pulse, honoured in IDLE only
//   finish                high while in DONE
//   M0_R_req/M0_addr      M0 read strobe and byte address
//   M0_R_data             M0 read data, valid the cycle after M0_R_req
//   M0_W_req/M0_W_data    tied off, M0 is read-only here
//   M1_R_req/M1_R_data    tied off / unused, M1 is write-only here
//   M1_W_req/M1_addr/M1_W_data  one full-word write per output pixel
module conv_engine #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int KER_BASE = 784,
  parameter int OUT_BASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic        M0_R_req,
  output logic [31:0] M0_addr,
  input  logic [31:0] M0_R_data,
  output logic [3:0]  M0_W_req,
  output logic [31:0] M0_W_data,
  output logic        M1_R_req,
  output logic [31:0] M1_addr,
  input  logic [31:0] M1_R_data,
  output logic [3:0]  M1_W_req,
  output logic [31:0] M1_W_data
);

  typedef enum logic [2:0] {IDLE, LOADK, CONV, WRITE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;        // step within LOADK (0..10) or CONV (0..9)
  logic [31:0] row;
  logic [31:0] col;
  logic [31:0] k [0:8];
  logic [31:0] bias;
  logic [31:0] acc;

  logic [3:0]  kidx;       // coefficient matching the data returning this cycle
  logic [31:0] prod;
  logic [31:0] wi;
  logic [31:0] wj;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic        last_col;
  logic        last_row;

  // Read data always belongs to the read issued one step earlier.
  assign kidx = cnt - 4'd1;
  assign prod = k[kidx] * M0_R_data;

  assign last_col = (col == 32'(IMG_W - 3));
  assign last_row = (row == 32'(IMG_H - 3));

  // Window offsets (i,j) for the read issued at step cnt, row-major.
  always_comb begin
    wi = 32'd0;
    wj = 32'd0;
    case (cnt)
      4'd0: begin wi = 32'd0; wj = 32'd0; end
      4'd1: begin wi = 32'd0; wj = 32'd1; end
      4'd2: begin wi = 32'd0; wj = 32'd2; end
      4'd3: begin wi = 32'd1; wj = 32'd0; end
      4'd4: begin wi = 32'd1; wj = 32'd1; end
      4'd5: begin wi = 32'd1; wj = 32'd2; end
      4'd6: begin wi = 32'd2; wj = 32'd0; end
      4'd7: begin wi = 32'd2; wj = 32'd1; end
      4'd8: begin wi = 32'd2; wj = 32'd2; end
      default: begin wi = 32'd0; wj = 32'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOADK;
      LOADK:   if (cnt == 4'd10) state_next = CONV;
      CONV:    if (cnt == 4'd9) state_next = WRITE;
      WRITE:   state_next = (last_col && last_row) ? DONE : CONV;
      DONE:    if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-facing outputs are decoded from state so that reset clears
  // them in the same instant it clears the state register.
  always_comb begin
    finish    = 1'b0;
    M0_R_req  = 1'b0;
    M0_W_req  = 4'b0000;
    M0_W_data = 32'd0;
    M1_R_req  = 1'b0;
    M1_W_req  = 4'b0000;
    M1_W_data = 32'd0;
    rd_word   = 32'd0;
    wr_word   = 32'd0;
    case (state)
      LOADK: begin
        if (cnt < 4'd10) begin
          M0_R_req = 1'b1;
          rd_word  = 32'(KER_BASE) + 32'(cnt);
        end
      end
      CONV: begin
        if (cnt < 4'd9) begin
          M0_R_req = 1'b1;
          rd_word  = (row + wi) * 32'(IMG_W) + col + wj;
        end
      end
      WRITE: begin
        M1_W_req  = 4'b1111;
        M1_W_data = acc;
        wr_word   = 32'(OUT_BASE) + row * 32'(IMG_W - 2) + col;
      end
      DONE: finish = 1'b1;
      default: ;
    endcase
    M0_addr = {rd_word[29:0], 2'b00};
    M1_addr = {wr_word[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 4'd0;
      row  <= 32'd0;
      col  <= 32'd0;
      acc  <= 32'd0;
      bias <= 32'd0;
      for (int n = 0; n < 9; n++) k[n] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (start) begin
            row <= 32'd0;
            col <= 32'd0;
          end
        end
        LOADK: begin
          // Step 0 only issues; steps 1..10 capture k[0..8] then bias.
          if (cnt == 4'd10) begin
            bias <= M0_R_data;
          end else if (cnt != 4'd0) begin
            k[kidx] <= M0_R_data;
          end
          cnt <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
        end
        CONV: begin
          if (cnt == 4'd0) begin
            acc <= bias;
          end else begin
            acc <= acc + prod;
          end
          cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end
        WRITE: begin
          cnt <= 4'd0;
          if (last_col) begin
            col <= 32'd0;
            row <= row + 32'd1;
          end else begin
            col <= col + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Testbench for conv_engine: behavioural M0 memory, scoreboard of expected
// M1 writes, directed runs covering constant, identity, wrap-around and
// random kernels, an ignored mid-run start and a mid-run reset.
module tb_conv_engine;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int OW   = W - 2;
  localparam int NOUT = (W - 2) * (H - 2);
  localparam int KB   = 784;

  logic        clk;
  logic        rst;
  logic        start;
  logic        finish;
  logic        M0_R_req;
  logic [31:0] M0_addr;
  logic [31:0] M0_R_data;
  logic [3:0]  M0_W_req;
  logic [31:0] M0_W_data;
  logic        M1_R_req;
  logic [31:0] M1_addr;
  logic [31:0] M1_R_data;
  logic [3:0]  M1_W_req;
  logic [31:0] M1_W_data;

  conv_engine dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .M0_R_req(M0_R_req), .M0_addr(M0_addr), .M0_R_data(M0_R_data),
    .M0_W_req(M0_W_req), .M0_W_data(M0_W_data),
    .M1_R_req(M1_R_req), .M1_addr(M1_addr), .M1_R_data(M1_R_data),
    .M1_W_req(M1_W_req), .M1_W_data(M1_W_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign M1_R_data = 32'd0;

  logic [31:0] mem0 [0:1023];
  logic [31:0] img [0:H-1][0:W-1];
  logic [31:0] ker [0:8];
  logic [31:0] kbias;

  always @(posedge clk) begin
    if (M0_R_req) M0_R_data <= mem0[M0_addr[11:2]];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cnt [0:NOUT-1];
  int   wr_total;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: protocol every cycle, scoreboard on every M1 write.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    n_checks++;
    assert (M0_W_req === 4'b0000 && M0_W_data === 32'd0 && M1_R_req === 1'b0 &&
            (M0_R_req === 1'b0 || M0_addr[1:0] === 2'b00))
    else begin
      n_fail++;
      $error("FAIL protocol: M0_W_req=%h M1_R_req=%b M0_addr=%h required 0/0/aligned",
             M0_W_req, M1_R_req, M0_addr);
    end
    if (M1_W_req !== 4'b0000) begin
      wr_total++;
      idx = int'(M1_addr >> 2);
      if (idx >= 0 && idx < NOUT) wr_cnt[idx]++;
      n_checks++;
      assert (M1_W_req === 4'b1111)
      else begin
        n_fail++;
        $error("FAIL m1_wreq: observed %h expected f", M1_W_req);
      end
      n_checks++;
      assert (exp_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_write: addr=%h data=%h expected no write", M1_addr, M1_W_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert (M1_addr === e.addr && M1_W_data === e.data)
        else begin
          n_fail++;
          $error("FAIL m1_write: observed addr=%h data=%h expected addr=%h data=%h",
                 M1_addr, M1_W_data, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] conv_ref(int r, int c);
    logic [31:0] s;
    s = kbias;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + ker[3*i+j] * img[r+i][c+j];
    return s;
  endfunction

  // mode 0: ones/ones/0   1: identity,bias 5, ramp   2: -1 kernel, 0x7FFFFFFF   3: random
  task automatic prep(input int mode);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (mode)
          0: img[r][c] = 32'd1;
          1: img[r][c] = 32'(r * W + c);
          2: img[r][c] = 32'h7FFFFFFF;
          default: img[r][c] = $urandom;
        endcase
        mem0[r*W+c] = img[r][c];
      end
    for (int n = 0; n < 9; n++) begin
      case (mode)
        0: ker[n] = 32'd1;
        1: ker[n] = (n == 4) ? 32'd1 : 32'd0;
        2: ker[n] = 32'hFFFFFFFF;
        default: ker[n] = $urandom;
      endcase
      mem0[KB+n] = ker[n];
    end
    kbias = (mode == 1) ? 32'd5 : (mode == 3) ? $urandom : 32'd0;
    mem0[KB+9] = kbias;
    exp_q.delete();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) begin
        e.addr = 32'((r * OW + c) * 4);
        case (mode)
          0: e.data = 32'h00000009;
          1: e.data = 32'((r + 1) * W + (c + 1) + 5);
          2: e.data = 32'h80000009;
          default: e.data = conv_ref(r, c);
        endcase
        exp_q.push_back(e);
      end
    for (int n = 0; n < NOUT; n++) wr_cnt[n] = 0;
    wr_total = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input string tag, input bit extra_start);
    int cyc;
    int once;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (cyc < 8000) begin
      @(negedge clk);
      cyc++;
      start = (extra_start && cyc == 100) ? 1'b1 : 1'b0;
      if (finish === 1'b1) break;
    end
    start = 1'b0;
    n_checks++;
    assert (finish === 1'b1 && cyc < 8000)
    else begin
      n_fail++;
      $error("FAIL %s_finish: observed finish=%b after %0d cycles expected 1 within 8000",
             tag, finish, cyc);
    end
    n_checks++;
    assert (exp_q.size() === 0)
    else begin
      n_fail++;
      $error("FAIL %s_pending: observed %0d outstanding expected 0", tag, exp_q.size());
    end
    n_checks++;
    assert (wr_total === NOUT)
    else begin
      n_fail++;
      $error("FAIL %s_wcount: observed %0d expected %0d", tag, wr_total, NOUT);
    end
    once = 0;
    for (int n = 0; n < NOUT; n++) if (wr_cnt[n] == 1) once++;
    n_checks++;
    assert (once === NOUT)
    else begin
      n_fail++;
      $error("FAIL %s_once: observed %0d addresses written once expected %0d", tag, once, NOUT);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      assert (finish === 1'b1)
      else begin
        n_fail++;
        $error("FAIL %s_hold: observed finish=%b expected 1", tag, finish);
      end
    end
    pulse_start();
    n_checks++;
    assert (finish === 1'b0)
    else begin
      n_fail++;
      $error("FAIL %s_leave_done: observed finish=%b expected 0", tag, finish);
    end
    $display("run %s: %0d cycles to finish, %0d writes", tag, cyc, wr_total);
  endtask

  task automatic check_quiet(input string tag);
    n_checks++;
    assert (finish === 1'b0 && M0_R_req === 1'b0 && M0_addr === 32'd0 &&
            M1_W_req === 4'b0000 && M1_addr === 32'd0 && M1_W_data === 32'd0)
    else begin
      n_fail++;
      $error("FAIL %s: observed fin=%b rreq=%b a0=%h wreq=%h a1=%h d1=%h expected all 0",
             tag, finish, M0_R_req, M0_addr, M1_W_req, M1_addr, M1_W_data);
    end
  endtask

  initial begin
    int saved;
    for (int n = 0; n < 1024; n++) mem0[n] = 32'd0;
    rst   = 1'b1;
    start = 1'b0;
    wr_total = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("idle_state");

    prep(0);
    run_full("ones", 1'b0);
    prep(1);
    run_full("identity", 1'b0);
    prep(2);
    run_full("wrap", 1'b0);
    prep(1);
    run_full("extra_start", 1'b1);

    // Abort a run with reset, then confirm a clean rerun.
    prep(3);
    pulse_start();
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("abort_outputs");
    @(negedge clk);
    rst = 1'b0;
    saved = wr_total;
    repeat (50) @(negedge clk);
    check_quiet("abort_idle");
    n_checks++;
    assert (wr_total === saved)
    else begin
      n_fail++;
      $error("FAIL abort_nowrite: observed %0d writes expected %0d", wr_total, saved);
    end
    $display("abort: %0d writes before reset", saved);
    prep(3);
    run_full("after_abort", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
